// File: rtl/sdes_round_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : sdes_round_sched_if
// Description : Request/response bundle for the S-DES round scheduler.
//               The master drives requests and accepts results; the slave
//               is the cipher engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdes_round_sched_if;
  logic       inValid;
  logic       inReady;
  logic       decrypt;
  logic [9:0] keyIn;
  logic [7:0] dataIn;
  logic       outValid;
  logic       outReady;
  logic [7:0] dataOut;
  logic       busy;

  modport master (
    output inValid, decrypt, keyIn, dataIn, outReady,
    input  inReady, outValid, dataOut, busy
  );

  modport slave (
    input  inValid, decrypt, keyIn, dataIn, outReady,
    output inReady, outValid, dataOut, busy
  );
endinterface : sdes_round_sched_if
`default_nettype wire

// File: rtl/sdes_round_sched.sv
`default_nettype none
// ============================================================================
// Module      : sdes_round_sched
// Description : Multi-cycle S-DES encrypt/decrypt engine. Latches key, block
//               and mode on accept, builds K1/K2, then runs both Feistel
//               rounds through one shared F datapath (EP, subkey XOR, S0/S1,
//               P4) and presents the result on a valid/ready port.
//               Optional build macro SDES_KEY_CACHE_EN: remembers the key of
//               the last completed key schedule and skips KEYGEN when the
//               next request uses the same key.
// Revision    : 1.0 - initial release
// ============================================================================
module sdes_round_sched (
  input  logic              clk,
  input  logic              rst_n,
  sdes_round_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYGEN = 3'd1,
    S_PERM   = 3'd2,
    S_RND1   = 3'd3,
    S_RND2   = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Fixed bit permutations (position 1 = MSB)
  // --------------------------------------------------------------------------
  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] d);
    return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] d);
    return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] r);
    return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] s);
    return {s[2], s[0], s[1], s[3]};
  endfunction

  // 5-bit half rotates used by the key schedule
  function automatic logic [4:0] ls1(input logic [4:0] h);
    return {h[3:0], h[4]};
  endfunction

  function automatic logic [4:0] ls2(input logic [4:0] h);
    return {h[2:0], h[4:3]};
  endfunction

  // --------------------------------------------------------------------------
  // S-boxes, indexed as {row, col} = {n[3], n[0], n[2], n[1]}
  // --------------------------------------------------------------------------
  function automatic logic [1:0] sbox0(input logic [3:0] n);
    logic [1:0] v;
    case ({n[3], n[0], n[2], n[1]})
      4'd0:  v = 2'd1;  4'd1:  v = 2'd0;  4'd2:  v = 2'd3;  4'd3:  v = 2'd2;
      4'd4:  v = 2'd3;  4'd5:  v = 2'd2;  4'd6:  v = 2'd1;  4'd7:  v = 2'd0;
      4'd8:  v = 2'd0;  4'd9:  v = 2'd2;  4'd10: v = 2'd1;  4'd11: v = 2'd3;
      4'd12: v = 2'd3;  4'd13: v = 2'd1;  4'd14: v = 2'd3;  default: v = 2'd2;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] sbox1(input logic [3:0] n);
    logic [1:0] v;
    case ({n[3], n[0], n[2], n[1]})
      4'd0:  v = 2'd0;  4'd1:  v = 2'd1;  4'd2:  v = 2'd2;  4'd3:  v = 2'd3;
      4'd4:  v = 2'd2;  4'd5:  v = 2'd0;  4'd6:  v = 2'd1;  4'd7:  v = 2'd3;
      4'd8:  v = 2'd3;  4'd9:  v = 2'd0;  4'd10: v = 2'd1;  4'd11: v = 2'd0;
      4'd12: v = 2'd2;  4'd13: v = 2'd1;  4'd14: v = 2'd0;  default: v = 2'd3;
    endcase
    return v;
  endfunction

  // Round function F(R, K)
  function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] k);
    logic [7:0] x;
    x = ep(r) ^ k;
    return p4({sbox0(x[7:4]), sbox1(x[3:0])});
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t     state_q,  state_d;
  logic       rdy_en_q, rdy_en_d;   // holds inReady low until reset has released
  logic [9:0] key_q,    key_d;
  logic [7:0] data_q,   data_d;
  logic       mode_q,   mode_d;     // 1 = decrypt
  logic [3:0] l_q,      l_d;
  logic [3:0] r_q,      r_d;
  logic [7:0] k1_q,     k1_d;
  logic [7:0] k2_q,     k2_d;
  logic [7:0] dout_q,   dout_d;

`ifdef SDES_KEY_CACHE_EN
  logic [9:0] cache_key_q, cache_key_d;
  logic       cache_vld_q, cache_vld_d;
`endif

  logic       w_accept;
  logic       w_cache_hit;
  logic [9:0] w_p10;
  logic [4:0] w_ls1_l, w_ls1_r;
  logic [7:0] w_k1, w_k2;
  logic [7:0] w_f_key;
  logic [3:0] w_f_out;

  // Key schedule from the latched key
  always_comb begin
    w_p10   = p10(key_q);
    w_ls1_l = ls1(w_p10[9:5]);
    w_ls1_r = ls1(w_p10[4:0]);
    w_k1    = p8({w_ls1_l, w_ls1_r});
    w_k2    = p8({ls2(w_ls1_l), ls2(w_ls1_r)});
  end

`ifdef SDES_KEY_CACHE_EN
  // Mode is deliberately excluded: both directions share one key schedule
  assign w_cache_hit = cache_vld_q && (bus.keyIn == cache_key_q);
`else
  assign w_cache_hit = 1'b0;
`endif

  // Single shared F: Ka in RND1, Kb in RND2; decrypt swaps subkey order
  always_comb begin
    if (state_q == S_RND1) w_f_key = mode_q ? k2_q : k1_q;
    else                   w_f_key = mode_q ? k1_q : k2_q;
    w_f_out = f_round(r_q, w_f_key);
  end

  assign bus.inReady  = rdy_en_q && (state_q == S_IDLE);
  assign bus.outValid = (state_q == S_OUT);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.dataOut  = dout_q;
  assign w_accept     = bus.inValid && bus.inReady;

  // Next-state and datapath updates for each sequencing step
  always_comb begin
    state_d  = state_q;
    rdy_en_d = 1'b1;
    key_d    = key_q;
    data_d   = data_q;
    mode_d   = mode_q;
    l_d      = l_q;
    r_d      = r_q;
    k1_d     = k1_q;
    k2_d     = k2_q;
    dout_d   = dout_q;
`ifdef SDES_KEY_CACHE_EN
    cache_key_d = cache_key_q;
    cache_vld_d = cache_vld_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          key_d   = bus.keyIn;
          data_d  = bus.dataIn;
          mode_d  = bus.decrypt;
          state_d = w_cache_hit ? S_PERM : S_KEYGEN;
        end
      end
      S_KEYGEN: begin
        k1_d    = w_k1;
        k2_d    = w_k2;
`ifdef SDES_KEY_CACHE_EN
        cache_key_d = key_q;
        cache_vld_d = 1'b1;
`endif
        state_d = S_PERM;
      end
      S_PERM: begin
        {l_d, r_d} = ip(data_q);
        state_d    = S_RND1;
      end
      S_RND1: begin
        // First round folded together with the half swap
        l_d     = r_q;
        r_d     = l_q ^ w_f_out;
        state_d = S_RND2;
      end
      S_RND2: begin
        dout_d  = ip_inv({l_q ^ w_f_out, r_q});
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.outReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
      key_q    <= '0;
      data_q   <= '0;
      mode_q   <= 1'b0;
      l_q      <= '0;
      r_q      <= '0;
      k1_q     <= '0;
      k2_q     <= '0;
      dout_q   <= '0;
`ifdef SDES_KEY_CACHE_EN
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rdy_en_q <= rdy_en_d;
      key_q    <= key_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      l_q      <= l_d;
      r_q      <= r_d;
      k1_q     <= k1_d;
      k2_q     <= k2_d;
      dout_q   <= dout_d;
`ifdef SDES_KEY_CACHE_EN
      cache_key_q <= cache_key_d;
      cache_vld_q <= cache_vld_d;
`endif
    end
  end

endmodule : sdes_round_sched
`default_nettype wire

// File: tb/tb_sdes_round_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdes_round_sched
// Description : Self-checking bench for sdes_round_sched: fixed vector table,
//               backpressure and mid-round reset sequences, then randomized
//               requests against a position-table S-DES reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdes_round_sched;

`ifdef SDES_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  sdes_round_sched_if bus ();

  sdes_round_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: generic permutation by position lists
  // --------------------------------------------------------------------------
  typedef int pos_t [10];
  pos_t P10 = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  pos_t P8  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
  pos_t IP  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
  pos_t IPI = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
  pos_t EP  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
  pos_t P4  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
  int   S0 [16] = '{1, 0, 3, 2,  3, 2, 1, 0,  0, 2, 1, 3,  3, 1, 3, 2};
  int   S1 [16] = '{0, 1, 2, 3,  2, 0, 1, 3,  3, 0, 1, 0,  2, 1, 0, 3};

  // Model key cache (only meaningful when the cache is built in)
  bit          m_cv;
  logic [9:0]  m_ck;

  function automatic int unsigned permute(int unsigned v, int n, int m, pos_t p);
    int unsigned o = 0;
    for (int i = 0; i < m; i++) o = (o << 1) | ((v >> (n - p[i])) & 1);
    return o;
  endfunction

  function automatic int unsigned rotl5(int unsigned x, int k);
    return ((x << k) | (x >> (5 - k))) & 31;
  endfunction

  function automatic int unsigned sb_index(int unsigned a);
    int unsigned row, col;
    row = ((a >> 3) & 1) * 2 + (a & 1);
    col = ((a >> 2) & 1) * 2 + ((a >> 1) & 1);
    return row * 4 + col;
  endfunction

  function automatic int unsigned f_model(int unsigned r, int unsigned k);
    int unsigned x, s0v, s1v;
    x   = permute(r, 4, 8, EP) ^ k;
    s0v = S0[sb_index(x >> 4)];
    s1v = S1[sb_index(x & 15)];
    return permute(s0v * 4 + s1v, 4, 4, P4);
  endfunction

  function automatic logic [7:0] sdes_model(logic [9:0] key, logic [7:0] data, logic dec);
    int unsigned p, hl, hr, k1, k2, ka, kb, ipv, lv, rv, t;
    p   = permute(key, 10, 10, P10);
    hl  = (p >> 5) & 31;
    hr  = p & 31;
    k1  = permute((rotl5(hl, 1) << 5) | rotl5(hr, 1), 10, 8, P8);
    k2  = permute((rotl5(hl, 3) << 5) | rotl5(hr, 3), 10, 8, P8);
    ka  = dec ? k2 : k1;
    kb  = dec ? k1 : k2;
    ipv = permute(data, 8, 8, IP);
    lv  = ipv >> 4;
    rv  = ipv & 15;
    t   = lv ^ f_model(rv, ka);
    lv  = rv;
    rv  = t;
    return 8'(permute(((lv ^ f_model(rv, kb)) << 4) | rv, 8, 8, IPI));
  endfunction

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full request: accept, latency, result, optional stall (with an
  // ignored concurrent request when poke=1), retire.
  task automatic do_req(input logic [9:0] key, input logic [7:0] data, input logic dec,
                        input int stall, input bit poke, output logic [7:0] got);
    logic [7:0] exp;
    bit         hit;
    int         exp_lat;
    int         w;
    int         lat;
    exp     = sdes_model(key, data, dec);
    hit     = CACHE_EN && m_cv && (key == m_ck);
    exp_lat = hit ? 3 : 4;
    bus.inValid  = 1'b1;
    bus.keyIn    = key;
    bus.dataIn   = data;
    bus.decrypt  = dec;
    bus.outReady = (stall == 0);
    w = 0;
    while (!bus.inReady && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_wait", {31'd0, bus.inReady}, 32'd1);
    @(posedge clk); #1;
    if (!hit) begin
      m_ck = key;
      m_cv = 1'b1;
    end
    bus.inValid = 1'b0;
    bus.keyIn   = 10'($urandom);
    bus.dataIn  = 8'($urandom);
    bus.decrypt = 1'($urandom);
    lat = 0;
    while (!bus.outValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_wait", {31'd0, bus.outValid}, 32'd1);
    chk("latency", lat, exp_lat);
    chk("data_out", {24'd0, bus.dataOut}, {24'd0, exp});
    got = bus.dataOut;
    if (poke) begin
      bus.inValid = 1'b1;
      bus.keyIn   = ~key;
      bus.dataIn  = ~data;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, bus.outValid}, 32'd1);
      chk("stall_busy",  {31'd0, bus.busy},     32'd1);
      chk("stall_ready", {31'd0, bus.inReady},  32'd0);
      chk("stall_data",  {24'd0, bus.dataOut},  {24'd0, exp});
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    @(posedge clk); #1;
    chk("retire_valid", {31'd0, bus.outValid}, 32'd0);
    chk("retire_busy",  {31'd0, bus.busy},     32'd0);
    chk("retire_ready", {31'd0, bus.inReady},  32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [9:0] key;
    logic [7:0] data;
    logic       dec;
    int         stall;
    bit         poke;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [6];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] got;
    logic [7:0] got2;
    logic [9:0] key;
    logic [9:0] last_key;
    logic [7:0] data;
    logic       dec;
    n_chk = 0;
    n_err = 0;
    m_cv  = 1'b0;
    m_ck  = '0;

    vt[0] = '{10'b1010000010, 8'b10010111, 1'b0, 0, 1'b0, 8'b00111000};
    vt[1] = '{10'b1010000010, 8'b00111000, 1'b1, 0, 1'b0, 8'b10010111};
    vt[2] = '{10'h000, 8'hA5, 1'b0, 2, 1'b0, sdes_model(10'h000, 8'hA5, 1'b0)};
    vt[3] = '{10'h3FF, 8'h00, 1'b1, 0, 1'b0, sdes_model(10'h3FF, 8'h00, 1'b1)};
    vt[4] = '{10'h3FF, 8'hFF, 1'b0, 6, 1'b1, sdes_model(10'h3FF, 8'hFF, 1'b0)};
    vt[5] = '{10'h1B4, 8'h5A, 1'b1, 1, 1'b0, sdes_model(10'h1B4, 8'h5A, 1'b1)};

    bus.inValid  = 1'b0;
    bus.decrypt  = 1'b0;
    bus.keyIn    = '0;
    bus.dataIn   = '0;
    bus.outReady = 1'b1;
    rst_n        = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, bus.inReady},  32'd0);
    chk("rst_out_valid", {31'd0, bus.outValid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},     32'd0);
    chk("rst_data_out",  {24'd0, bus.dataOut},  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, bus.inReady}, 32'd1);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      do_req(vt[i].key, vt[i].data, vt[i].dec, vt[i].stall, vt[i].poke, got);
      chk("table_result", {24'd0, got}, {24'd0, vt[i].exp});
      if (i == 0) begin
        chk("k1", {24'd0, dut.k1_q}, 32'h0000_00A4);
        chk("k2", {24'd0, dut.k2_q}, 32'h0000_0043);
      end
    end

    // Reset asserted in RND1 discards the in-flight request
    key = m_ck ^ 10'h001;
    bus.inValid = 1'b1;
    bus.keyIn   = key;
    bus.dataIn  = 8'h3C;
    bus.decrypt = 1'b0;
    chk("mid_rst_ready", {31'd0, bus.inReady}, 32'd1);
    @(posedge clk); #1;       // accept -> KEYGEN
    bus.inValid = 1'b0;
    @(posedge clk); #1;       // PERM
    @(posedge clk); #1;       // RND1
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  {31'd0, bus.inReady},  32'd0);
    chk("mid_rst_out_valid", {31'd0, bus.outValid}, 32'd0);
    chk("mid_rst_busy",      {31'd0, bus.busy},     32'd0);
    chk("mid_rst_data_out",  {24'd0, bus.dataOut},  32'd0);
    m_cv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_stale_valid", {31'd0, bus.outValid}, 32'd0);
      chk("no_stale_busy",  {31'd0, bus.busy},     32'd0);
    end
    do_req(10'h000, 8'hA5, 1'b0, 0, 1'b0, got);

    // Randomized requests, with round-trip checks
    last_key = 10'h000;
    for (int n = 0; n < 1000; n++) begin
      key  = ($urandom_range(0, 3) == 0) ? last_key : 10'($urandom);
      data = 8'($urandom);
      dec  = 1'($urandom);
      do_req(key, data, dec, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
             1'b0, got);
      if ($urandom_range(0, 3) == 0) begin
        do_req(key, got, ~dec, 0, 1'b0, got2);
        chk("round_trip", {24'd0, got2}, {24'd0, data});
      end
      last_key = key;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_sdes_round_sched
`default_nettype wire

// File: doc/sdes_round_sched.md
# sdes_round_sched

Multi-cycle S-DES encrypt/decrypt engine controller. It accepts a 10-bit key and an 8-bit block over a valid/ready handshake, generates subkeys K1/K2, and sequences a single shared Fk datapath through both rounds. The datapath is EP, subkey XOR, S0/S1 lookup and P4. The result is returned on a valid/ready output port. It sits above the S0/S1 substitution boxes and is the top-level cipher block of the function library.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- inValid  in  1  request valid
- inReady  out  1  engine can accept a request (IDLE only)
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- keyIn  in  10  cipher key, bit 9 = key position 1; sampled on accept
- dataIn  in  8  plaintext/ciphertext, bit 7 = position 1; sampled on accept
- outValid  out  1  result valid
- outReady  in  1  consumer accepts result
- dataOut  out  8  result block
- busy  out  1  high in every state except IDLE

## Operation
- Bit positions are numbered 1 = MSB.
- P10 = 3 5 2 7 4 10 1 9 8 6.
- P8 = 6 3 7 4 8 5 10 9.
- IP = 2 6 3 1 4 8 5 7.
- IP⁻¹ = 4 1 3 5 7 2 8 6.
- EP = 4 1 2 3 2 3 4 1.
- P4 = 2 4 3 1.
- Key schedule: K1 = P8(LS1 halves of P10(key)); K2 = P8(LS2 of those halves), where LS is a per-5-bit-half left rotate.
- S-box addressing: for 4-bit input n, row = {n[3],n[0]} and col = {n[2],n[1]}.
- S0 rows: 1 0 3 2 / 3 2 1 0 / 0 2 1 3 / 3 1 3 2.
- S1 rows: 0 1 2 3 / 2 0 1 3 / 3 0 1 0 / 2 1 0 3.
- F(R,K) = P4({S0(x[7:4]), S1(x[3:0])}), with x = EP(R) ^ K.
- Only one F instance exists. Its subkey is muxed by state: encrypt uses K1 then K2; decrypt uses K2 then K1.
- FSM states:
  - IDLE: inReady=1. On inValid, latch key, data and mode, then go to KEYGEN.
  - KEYGEN: register K1/K2 → PERM.
  - PERM: {L,R} ← IP(data) → RND1.
  - RND1: L ← R, R ← L ^ F(R,Ka) (includes the SW swap) → RND2.
  - RND2: dataOut ← IP⁻¹({L ^ F(R,Kb), R}) → OUT.
  - OUT: outValid=1. dataOut is held stable until outReady; outValid && outReady → IDLE.
- A new request cannot be accepted in the same cycle a result retires. inReady rises the cycle after the OUT→IDLE transition.
- inValid is ignored outside IDLE. keyIn, dataIn and decrypt may change freely after acceptance.

## Timing
- Reset values: inReady=0 during reset, then 1 from the first cycle after reset release; outValid=0, dataOut=8'h00, busy=0; FSM=IDLE; L/R/K1/K2 are 0; cache invalid.
- Accept edge = rising edge where inValid && inReady.
- Latency: outValid is high 4 cycles after the accept edge (KEYGEN, PERM, RND1, RND2). On a key-cache hit it is 3 cycles.
- Minimum issue interval is 6 cycles with outReady tied high (5 on a cache hit).
- Asserting rst_n low at any point, including mid-round or in OUT with outValid high, immediately forces all reset values. The in-flight result is discarded and no outValid pulse appears.

## Configuration
- Macro: SDES_KEY_CACHE_EN.
- Defined:
  - Each completed KEYGEN stores keyIn and sets a cache-valid bit.
  - On accept, if the cache is valid and keyIn equals the stored key, the FSM goes IDLE→PERM and reuses K1/K2.
  - Reset clears cache-valid.
- Undefined: no cache storage; every request passes through KEYGEN (fixed 4-cycle latency).
- The mode (encrypt/decrypt) never affects cache hit or miss.

## Test plan
- Encrypt: key 10'b1010000010, data 8'b10010111, outReady=1 → K1=10100100, K2=01000011. dataOut=8'b00111000 with outValid 4 cycles after accept, for exactly 1 cycle.
- Decrypt: same key, data 8'b00111000 → dataOut=8'b10010111. With SDES_KEY_CACHE_EN, a repeat of the same key gives latency 3 cycles; a different key gives 4.
- Backpressure: hold outReady=0 for 6 cycles after outValid → dataOut, outValid=1 and busy=1 stay stable. inReady=0 and a concurrent inValid is ignored. Retire on outReady, then inReady=1 the next cycle.
- Reset mid-operation: assert rst_n=0 in RND1 → all outputs are at reset values that cycle. After release, the next request (key 0, data 8'hA5) matches the golden model, and no stale result appears.
- Random: 1000 requests with random key/data/mode and random outReady stalls, checked against the software S-DES model. Every decrypt(encrypt(p)) with the same key returns p.
